// File: rtl/audio_frame_loader_if.sv
// audio_frame_loader_if: sample stream in, parallel frame out, plus the
// transmitter's frame tick and underrun reporting.
interface audio_frame_loader_if #(
    parameter int unsigned NUM_SAMPLES = 32,
    parameter int unsigned SAMPLE_W    = 8,
    parameter int unsigned CNT_W       = 16
);
    logic [SAMPLE_W-1:0] s_data;
    logic                s_valid;
    logic                s_ready;
    logic                frame_tick;
    logic [SAMPLE_W-1:0] audio_data [NUM_SAMPLES-1:0];
    logic                frame_valid;
    logic                underrun;
    logic [CNT_W-1:0]    underrun_cnt;

    // Upstream feeder / transmitter side
    modport master (
        output s_data, s_valid, frame_tick,
        input  s_ready, audio_data, frame_valid, underrun, underrun_cnt
    );

    // Loader side
    modport slave (
        input  s_data, s_valid, frame_tick,
        output s_ready, audio_data, frame_valid, underrun, underrun_cnt
    );
endinterface

// File: rtl/audio_frame_loader.sv
// audio_frame_loader: assembles a byte stream into NUM_SAMPLES-sample frames in
// a ping-pong buffer and swaps banks on the transmitter's frame tick.
// Optional build macro AUDIO_FRAME_MUTE_ON_UNDERRUN_EN: an underrun mutes the
// output bank to mid-scale and clears frame_valid until the next swap.
module audio_frame_loader #(
    parameter int unsigned NUM_SAMPLES = 32,
    parameter int unsigned SAMPLE_W    = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    audio_frame_loader_if.slave bus
);
    localparam int unsigned       IDX_W    = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_SAMPLES - 1);
`ifdef AUDIO_FRAME_MUTE_ON_UNDERRUN_EN
    localparam logic [SAMPLE_W-1:0] MID_SCALE = SAMPLE_W'(1) << (SAMPLE_W - 1);
`endif

    typedef enum logic {
        ST_FILL,
        ST_FULL
    } state_t;

    state_t              state;
    logic                ptr;
    logic [IDX_W-1:0]    wr_idx;
    logic [SAMPLE_W-1:0] bank [2][NUM_SAMPLES-1:0];

    logic                accept;
    logic                last_accept;
    logic                fill_sel;

    // Handshake qualification; out bank is bank[ptr], fill bank the other one
    assign accept      = (state == ST_FILL) && bus.s_ready && bus.s_valid;
    assign last_accept = accept && (wr_idx == LAST_IDX);
    assign fill_sel    = ~ptr;

    // Output frame is the out bank selected by the registered pointer
    always_comb begin
        for (int i = 0; i < int'(NUM_SAMPLES); i++) begin
            bus.audio_data[i] = bank[ptr][i];
        end
    end

    // Fill/full state machine, bank swap and underrun accounting
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < int'(NUM_SAMPLES); i++) begin
                    bank[b][i] <= '0;
                end
            end
            state            <= ST_FILL;
            ptr              <= 1'b0;
            wr_idx           <= '0;
            bus.s_ready      <= 1'b0;
            bus.frame_valid  <= 1'b0;
            bus.underrun     <= 1'b0;
            bus.underrun_cnt <= '0;
        end else begin
            bus.underrun <= 1'b0;

            if (accept) begin
                bank[fill_sel][wr_idx] <= bus.s_data;
                wr_idx                 <= wr_idx + 1'b1;
            end

            case (state)
                ST_FILL: begin
                    bus.s_ready <= 1'b1;
                    if (bus.frame_tick && last_accept) begin
                        // Last sample lands in the same cycle as the tick: swap directly
                        ptr             <= ~ptr;
                        bus.frame_valid <= 1'b1;
                        wr_idx          <= '0;
                    end else begin
                        if (last_accept) begin
                            state       <= ST_FULL;
                            bus.s_ready <= 1'b0;
                        end
                        if (bus.frame_tick) begin
                            // Tick with a partial fill: report it, keep filling
                            bus.underrun <= 1'b1;
                            if (bus.underrun_cnt != '1) begin
                                bus.underrun_cnt <= bus.underrun_cnt + 1'b1;
                            end
`ifdef AUDIO_FRAME_MUTE_ON_UNDERRUN_EN
                            for (int i = 0; i < int'(NUM_SAMPLES); i++) begin
                                bank[ptr][i] <= MID_SCALE;
                            end
                            bus.frame_valid <= 1'b0;
`else
                            // Out bank keeps repeating the previous frame
`endif
                        end
                    end
                end
                ST_FULL: begin
                    bus.s_ready <= 1'b0;
                    if (bus.frame_tick) begin
                        ptr             <= ~ptr;
                        bus.frame_valid <= 1'b1;
                        wr_idx          <= '0;
                        state           <= ST_FILL;
                        bus.s_ready     <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_audio_frame_loader.sv
// tb_audio_frame_loader: table-driven frame sequences plus directed corner cases
// (coincident tick, mid-fill reset, counter saturation on a 4-bit instance).
module tb_audio_frame_loader;
    localparam int N = 32;
    localparam int W = 8;

    localparam int K_ZERO = 0;
    localparam int K_RAMP = 1;
    localparam int K_MID  = 2;

    logic clk = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    audio_frame_loader_if #(.NUM_SAMPLES(N), .SAMPLE_W(W), .CNT_W(16)) if0 ();
    audio_frame_loader_if #(.NUM_SAMPLES(N), .SAMPLE_W(W), .CNT_W(4))  if1 ();

    audio_frame_loader #(.NUM_SAMPLES(N), .SAMPLE_W(W), .CNT_W(16)) u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    audio_frame_loader #(.NUM_SAMPLES(N), .SAMPLE_W(W), .CNT_W(4)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    typedef struct {
        int nbeats;
        int base;
        bit gaps;
        bit tick;
        int exp_ready;
        int exp_fv;
        int exp_under;
        int exp_cnt;
        int kind;
        int exp_base;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_frame(input string name, input int kind, input int base);
        int             bad;
        logic [W-1:0]   e;
        logic [W-1:0]   e_bad;
        logic [W-1:0]   g_bad;
        bad   = -1;
        e_bad = '0;
        g_bad = '0;
        for (int i = 0; i < N; i++) begin
            case (kind)
                K_ZERO:  e = '0;
                K_RAMP:  e = W'(base + i);
                default: e = 8'h80;
            endcase
            if (if0.audio_data[i] !== e && bad < 0) begin
                bad   = i;
                e_bad = e;
                g_bad = if0.audio_data[i];
            end
        end
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: audio_data[%0d] got %0h expected %0h", name, bad, g_bad, e_bad);
        end
    endtask

    // Stream n beats of base+k; every step starts just after a rising edge
    task automatic feed(input int n, input int base, input bit gaps);
        for (int k = 0; k < n; k++) begin
            int waited;
            waited = 0;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    if0.s_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            if0.s_valid = 1'b1;
            if0.s_data  = W'(base + k);
            while (!if0.s_ready) begin
                @(posedge clk);
                #1;
                waited++;
                if (waited > 100) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL feed_timeout: s_ready stayed 0 at beat %0d, expected 1", k);
                    if0.s_valid = 1'b0;
                    return;
                end
            end
            @(posedge clk);
            #1;
        end
        if0.s_valid = 1'b0;
    endtask

    task automatic tick();
        if0.frame_tick = 1'b1;
        @(posedge clk);
        #1;
        if0.frame_tick = 1'b0;
    endtask

    task automatic resync();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation not finished after 1000000 ns, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{32, 'h00, 1'b0, 1'b0, 0, 0, 0, 0, K_ZERO, 'h00};
        vecs[1] = '{ 0, 'h00, 1'b0, 1'b1, 1, 1, 0, 0, K_RAMP, 'h00};
        vecs[2] = '{32, 'h40, 1'b1, 1'b1, 1, 1, 0, 0, K_RAMP, 'h40};
        vecs[3] = '{32, 'h80, 1'b1, 1'b1, 1, 1, 0, 0, K_RAMP, 'h80};
`ifdef AUDIO_FRAME_MUTE_ON_UNDERRUN_EN
        vecs[4] = '{10, 'h20, 1'b0, 1'b1, 1, 0, 1, 1, K_MID,  'h00};
        vecs[5] = '{22, 'h2A, 1'b0, 1'b0, 0, 0, 0, 1, K_MID,  'h00};
`else
        vecs[4] = '{10, 'h20, 1'b0, 1'b1, 1, 1, 1, 1, K_RAMP, 'h80};
        vecs[5] = '{22, 'h2A, 1'b0, 1'b0, 0, 1, 0, 1, K_RAMP, 'h80};
`endif
        vecs[6] = '{ 0, 'h00, 1'b0, 1'b1, 1, 1, 0, 1, K_RAMP, 'h20};

        reset          = 1'b1;
        if0.s_valid    = 1'b0;
        if0.s_data     = '0;
        if0.frame_tick = 1'b0;
        if1.s_valid    = 1'b0;
        if1.s_data     = '0;
        if1.frame_tick = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst s_ready", int'(if0.s_ready), 0);
        chk("rst frame_valid", int'(if0.frame_valid), 0);
        chk("rst underrun", int'(if0.underrun), 0);
        chk("rst underrun_cnt", int'(if0.underrun_cnt), 0);
        chk("rst cnt4", int'(if1.underrun_cnt), 0);
        chk_frame("rst audio_data", K_ZERO, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        resync();
        @(negedge clk);
        chk("post-rst s_ready", int'(if0.s_ready), 1);
        resync();

        // Table-driven frame sequences
        for (int r = 0; r < 7; r++) begin
            feed(vecs[r].nbeats, vecs[r].base, vecs[r].gaps);
            if (vecs[r].tick) tick();
            @(negedge clk);
            chk($sformatf("v%0d s_ready", r), int'(if0.s_ready), vecs[r].exp_ready);
            chk($sformatf("v%0d frame_valid", r), int'(if0.frame_valid), vecs[r].exp_fv);
            chk($sformatf("v%0d underrun", r), int'(if0.underrun), vecs[r].exp_under);
            chk($sformatf("v%0d underrun_cnt", r), int'(if0.underrun_cnt), vecs[r].exp_cnt);
            chk_frame($sformatf("v%0d audio_data", r), vecs[r].kind, vecs[r].exp_base);
            resync();
        end

        // Tick coincident with the last accepted beat
        feed(31, 'h60, 1'b0);
        chk("coin s_ready before", int'(if0.s_ready), 1);
        if0.s_valid    = 1'b1;
        if0.s_data     = 8'h7F;
        if0.frame_tick = 1'b1;
        @(posedge clk);
        #1;
        if0.s_valid    = 1'b0;
        if0.frame_tick = 1'b0;
        @(negedge clk);
        chk("coin underrun", int'(if0.underrun), 0);
        chk("coin underrun_cnt", int'(if0.underrun_cnt), 1);
        chk("coin s_ready", int'(if0.s_ready), 1);
        chk("coin frame_valid", int'(if0.frame_valid), 1);
        chk_frame("coin audio_data", K_RAMP, 'h60);
        resync();
        feed(32, 'hA0, 1'b0);
        tick();
        @(negedge clk);
        chk_frame("post-coin audio_data", K_RAMP, 'hA0);
        resync();

        // Reset in the middle of a fill
        feed(20, 'h90, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst frame_valid", int'(if0.frame_valid), 0);
        chk("midrst underrun_cnt", int'(if0.underrun_cnt), 0);
        chk("midrst s_ready", int'(if0.s_ready), 0);
        chk_frame("midrst audio_data", K_ZERO, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        resync();
        feed(32, 'hC0, 1'b0);
        tick();
        @(negedge clk);
        chk("refill frame_valid", int'(if0.frame_valid), 1);
        chk("refill underrun_cnt", int'(if0.underrun_cnt), 0);
        chk_frame("refill audio_data", K_RAMP, 'hC0);
        resync();

        // Saturating 4-bit underrun counter
        for (int k = 1; k <= 20; k++) begin
            if1.frame_tick = 1'b1;
            @(posedge clk);
            #1;
            if1.frame_tick = 1'b0;
            @(negedge clk);
            chk($sformatf("sat%0d underrun", k), int'(if1.underrun), 1);
            chk($sformatf("sat%0d cnt", k), int'(if1.underrun_cnt), (k > 15) ? 15 : k);
            resync();
        end
        @(negedge clk);
        chk("sat underrun cleared", int'(if1.underrun), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
